// File: rtl/bram_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter, its two requesters and the BRAM.
// slave: the arbiter's view. master: the requester/BRAM side (testbench).
// Flow control is grant/ready per cycle; read returns flagged by rvalid.
interface bram_arbiter_if #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 15
);
  // video pixel-fetch path (read-only)
  logic                     vid_req;
  logic [RAM_ADDR_BITS-1:0] vid_addr;
  logic                     vid_grant;
  logic                     vid_rvalid;
  logic [RAM_WIDTH-1:0]     vid_rdata;
  // host read/write port
  logic                     host_valid;
  logic                     host_we;
  logic [RAM_ADDR_BITS-1:0] host_addr;
  logic [RAM_WIDTH-1:0]     host_wdata;
  logic                     host_ready;
  logic                     host_rvalid;
  logic [RAM_WIDTH-1:0]     host_rdata;
  // BRAM command/return
  logic                     ram_enable;
  logic                     write_enable;
  logic [RAM_ADDR_BITS-1:0] ram_address;
  logic [RAM_WIDTH-1:0]     ram_wdata;
  logic [RAM_WIDTH-1:0]     ram_rdata;

  modport slave (
    input  vid_req, vid_addr,
    output vid_grant, vid_rvalid, vid_rdata,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata,
    output ram_enable, write_enable, ram_address, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_grant, vid_rvalid, vid_rdata,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata,
    input  ram_enable, write_enable, ram_address, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// Shares a single-port BRAM between video fetch (priority) and a host port.
// Latency: command issues combinationally; read data returns 1 cycle later.
// Backpressure: video loses a denied cycle; host holds until host_ready, forced in after STARVE_LIMIT losses.
module bram_arbiter #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 15,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  bram_arbiter_if.slave  bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VID  = 2'd1,
    SRC_HOST = 2'd2
  } src_t;

  src_t       rd_src;
  logic [7:0] starve_cnt;
  logic       force_host;
  logic       vid_grant;
  logic       host_ready;
  logic       host_grant;

  // Host steals the slot only once video has won STARVE_LIMIT times in a row.
  assign force_host = bus.host_valid && bus.vid_req && (starve_cnt == LIMIT);
  assign vid_grant  = bus.vid_req && !force_host;
  assign host_ready = !bus.vid_req || force_host;
  assign host_grant = bus.host_valid && host_ready;

  assign bus.vid_grant    = vid_grant;
  assign bus.host_ready   = host_ready;
  assign bus.ram_enable   = vid_grant || host_grant;
  assign bus.write_enable = host_grant && bus.host_we;

  // Command mux: the grants are mutually exclusive; idle drives zeros.
  always_comb begin
    bus.ram_address = '0;
    bus.ram_wdata   = '0;
    if (vid_grant) begin
      bus.ram_address = bus.vid_addr;
    end else if (host_grant) begin
      bus.ram_address = bus.host_addr;
      bus.ram_wdata   = bus.host_wdata;
    end
  end

  // Count consecutive host-blocked video grants; any host win or host withdrawal restarts it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 8'd0;
    end else if (!bus.host_valid || host_grant) begin
      starve_cnt <= 8'd0;
    end else if (vid_grant && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Tag each issued read so the BRAM's registered output goes back to its issuer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_src <= SRC_NONE;
    end else if (vid_grant) begin
      rd_src <= SRC_VID;
    end else if (host_grant && !bus.host_we) begin
      rd_src <= SRC_HOST;
    end else begin
      rd_src <= SRC_NONE;
    end
  end

  assign bus.vid_rvalid  = (rd_src == SRC_VID);
  assign bus.host_rvalid = (rd_src == SRC_HOST);
  // Both sides see the raw BRAM output; rvalid qualifies it.
  assign bus.vid_rdata   = bus.ram_rdata;
  assign bus.host_rdata  = bus.ram_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural 1-cycle BRAM.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Preloaded memory word at address a is 32'hC0DE0000 + a.
module tb_bram_arbiter;

  localparam int W = 32;
  localparam int A = 15;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  bram_arbiter_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) bus ();

  bram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .STARVE_LIMIT(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [W-1:0] mem [0:(1<<A)-1];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BRAM model: registered read, write committed at the edge.
  always @(posedge clock) begin
    if (bus.ram_enable) begin
      if (bus.write_enable) mem[bus.ram_address] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_address];
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.vid_req    = 1'b0;
    bus.vid_addr   = '0;
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask

  logic [A-1:0] iaddr [0:5];
  logic         ishost[0:5];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < (1 << A); i++) mem[i] = 32'hC0DE0000 + i;
    bus.ram_rdata = '0;
    idle();
    reset_n = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clock);
    #1;
    chk("rst_vid_rvalid", 32'(bus.vid_rvalid), 32'd0);
    chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    chk("rst_idle_en", 32'(bus.ram_enable), 32'd0);
    reset_n = 1'b1;
    step();

    // ---------------- video stream 0..15 ----------------
    for (int i = 0; i < 16; i++) begin
      bus.vid_req  = 1'b1;
      bus.vid_addr = 15'(i);
      @(negedge clock);
      chk("vs_grant", 32'(bus.vid_grant), 32'd1);
      chk("vs_addr", 32'(bus.ram_address), 32'(i));
      if (i > 0) begin
        chk("vs_rvalid", 32'(bus.vid_rvalid), 32'd1);
        chk("vs_rdata", bus.vid_rdata, 32'hC0DE0000 + 32'(i - 1));
        chk("vs_no_host_rvalid", 32'(bus.host_rvalid), 32'd0);
      end
      step();
    end
    idle();
    @(negedge clock);
    chk("vs_last_rvalid", 32'(bus.vid_rvalid), 32'd1);
    chk("vs_last_rdata", bus.vid_rdata, 32'hC0DE000F);
    chk("idle_en", 32'(bus.ram_enable), 32'd0);
    chk("idle_addr", 32'(bus.ram_address), 32'd0);
    step();
    @(negedge clock);
    chk("idle_vid_rvalid", 32'(bus.vid_rvalid), 32'd0);
    chk("idle_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    step();

    // ---------------- host write then read-back ----------------
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 15'h0010;
    bus.host_wdata = 32'hDEADBEEF;
    @(negedge clock);
    chk("hw_ready", 32'(bus.host_ready), 32'd1);
    chk("hw_we", 32'(bus.write_enable), 32'd1);
    chk("hw_en", 32'(bus.ram_enable), 32'd1);
    chk("hw_wdata", bus.ram_wdata, 32'hDEADBEEF);
    step();
    bus.host_we = 1'b0;
    @(negedge clock);
    chk("hr_ready", 32'(bus.host_ready), 32'd1);
    chk("hr_we", 32'(bus.write_enable), 32'd0);
    chk("hw_no_rvalid", 32'(bus.host_rvalid), 32'd0);
    step();
    idle();
    @(negedge clock);
    chk("hr_rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("hr_rdata", bus.host_rdata, 32'hDEADBEEF);
    chk("hr_no_vid_rvalid", 32'(bus.vid_rvalid), 32'd0);
    step();

    // ---------------- starvation ----------------
    bus.vid_req    = 1'b1;
    bus.vid_addr   = 15'h0020;
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 15'h0011;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("sv_vid_grant", 32'(bus.vid_grant), (c == 8) ? 32'd0 : 32'd1);
      chk("sv_host_ready", 32'(bus.host_ready), (c == 8) ? 32'd1 : 32'd0);
      if (c <= 8) chk("sv_starve", 32'(dut.starve_cnt), 32'(c));
      if (c == 8) chk("sv_host_addr", 32'(bus.ram_address), 32'h0011);
      if (c == 9) begin
        chk("sv_starve_clr", 32'(dut.starve_cnt), 32'd0);
        chk("sv_host_rvalid", 32'(bus.host_rvalid), 32'd1);
        chk("sv_host_rdata", bus.host_rdata, 32'hC0DE0011);
        chk("sv_no_vid_rvalid", 32'(bus.vid_rvalid), 32'd0);
      end
      step();
      if (c == 8) bus.host_valid = 1'b0;
    end
    idle();
    step();

    // ---------------- interleaved tags ----------------
    iaddr[0] = 15'h0030; ishost[0] = 1'b1;
    iaddr[1] = 15'h0040; ishost[1] = 1'b0;
    iaddr[2] = 15'h0031; ishost[2] = 1'b1;
    iaddr[3] = 15'h0041; ishost[3] = 1'b0;
    iaddr[4] = 15'h0032; ishost[4] = 1'b1;
    iaddr[5] = 15'h0042; ishost[5] = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      idle();
      if (i < 6) begin
        if (ishost[i]) begin
          bus.host_valid = 1'b1;
          bus.host_addr  = iaddr[i];
        end else begin
          bus.vid_req  = 1'b1;
          bus.vid_addr = iaddr[i];
        end
      end
      @(negedge clock);
      if (i > 0) begin
        chk("il_host_rvalid", 32'(bus.host_rvalid), 32'(ishost[i-1]));
        chk("il_vid_rvalid", 32'(bus.vid_rvalid), 32'(!ishost[i-1]));
        chk("il_rdata", bus.ram_rdata, 32'hC0DE0000 + 32'(iaddr[i-1]));
      end
      step();
    end

    // ---------------- host abort and restart ----------------
    bus.vid_req    = 1'b1;
    bus.vid_addr   = 15'h0050;
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 15'h0012;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("ab_blocked", 32'(bus.host_ready), 32'd0);
      step();
    end
    bus.host_valid = 1'b0;
    @(negedge clock);
    chk("ab_starve_3", 32'(dut.starve_cnt), 32'd3);
    step();
    bus.host_valid = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      chk("ab_starve", 32'(dut.starve_cnt), 32'(c));
      chk("ab_host_ready", 32'(bus.host_ready), (c == 8) ? 32'd1 : 32'd0);
      step();
    end
    bus.host_valid = 1'b0;
    @(negedge clock);
    chk("ab_host_rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("ab_host_rdata", bus.host_rdata, 32'hC0DE0012);
    step();
    idle();
    step();

    // ---------------- reset mid-read ----------------
    bus.vid_req  = 1'b1;
    bus.vid_addr = 15'h0005;
    step();
    bus.vid_addr = 15'h0006;
    @(negedge clock);
    chk("rm_grant", 32'(bus.vid_grant), 32'd1);
    chk("rm_rvalid_before", 32'(bus.vid_rvalid), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rm_rvalid_immediate", 32'(bus.vid_rvalid), 32'd0);
    @(posedge clock);
    #1;
    chk("rm_rvalid_after", 32'(bus.vid_rvalid), 32'd0);
    chk("rm_starve", 32'(dut.starve_cnt), 32'd0);
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    step();
    // BRAM contents survive the arbiter reset
    bus.host_valid = 1'b1;
    bus.host_addr  = 15'h0010;
    @(negedge clock);
    chk("rm_vid_rvalid_idle", 32'(bus.vid_rvalid), 32'd0);
    step();
    idle();
    @(negedge clock);
    chk("rm_readback_valid", 32'(bus.host_rvalid), 32'd1);
    chk("rm_readback_data", bus.host_rdata, 32'hDEADBEEF);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
